// File: rtl/weight_loader_pkg.sv
// ============================================================================
// Module      : weight_loader_pkg
// Description : Shared constants and state encoding for the kernel weight
//               loader and the 6-entry, 72-bit kernel weight buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package weight_loader_pkg;

    localparam int BYTE_W      = 8;
    localparam int TAPS        = 9;
    localparam int NUM_KERNELS = 6;
    localparam int IDX_W       = 3;
    localparam int KWORD_W     = BYTE_W * TAPS;
    localparam int BCNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/weight_loader_if.sv
// ============================================================================
// Module      : weight_loader_if
// Description : Byte stream handshake from upstream plus the write port of
//               the kernel weight buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface weight_loader_if;
    import weight_loader_pkg::*;

    logic                in_valid;
    logic [BYTE_W-1:0]   in_data;
    logic                in_ready;
    logic                readen;
    logic [IDX_W-1:0]    in_index;
    logic [KWORD_W-1:0]  weight_data;

    // Upstream / environment side
    modport master (
        output in_valid, in_data,
        input  in_ready, readen, in_index, weight_data
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, readen, in_index, weight_data
    );
endinterface

`default_nettype wire

// File: rtl/weight_loader_packer.sv
// ============================================================================
// Module      : weight_packer
// Description : Shifts accepted weight bytes into a kernel word; emits the
//               packed 72-bit word with a one-cycle valid after every 9th byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_packer
    import weight_loader_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                clear_i,
    input  wire logic                accept_i,
    input  wire logic [BYTE_W-1:0]   data_i,
    output logic [KWORD_W-1:0]       word_o,
    output logic                     word_valid_o,
    output logic                     last_byte_o
);

    // Only the first eight bytes need staging; the ninth goes straight
    // into the output word, so the published word holds while the next
    // kernel streams in.
    logic [KWORD_W-BYTE_W-1:0] sreg_q;
    logic [BCNT_W-1:0]         bcnt_q;
    logic [KWORD_W-1:0]        word_q;
    logic                      valid_q;

    assign last_byte_o  = (bcnt_q == BCNT_W'(TAPS - 1));
    assign word_o       = word_q;
    assign word_valid_o = valid_q;

    // Byte shifting, tap counting and word publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                sreg_q <= '0;
                bcnt_q <= '0;
            end else if (accept_i) begin
                sreg_q <= {sreg_q[KWORD_W-2*BYTE_W-1:0], data_i};
                if (last_byte_o) begin
                    bcnt_q  <= '0;
                    word_q  <= {sreg_q, data_i};
                    valid_q <= 1'b1;
                end else begin
                    bcnt_q <= bcnt_q + BCNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/weight_loader.sv
// ============================================================================
// Module      : weight_loader
// Description : Loads a programmable number of 3x3 kernels from a byte
//               stream into the kernel weight buffer and signals completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader
    import weight_loader_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [IDX_W-1:0]  kernel_cnt,
    output logic                   busy,
    output logic                   done,
    weight_loader_if.slave         bus
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  kc_q;
    logic [IDX_W-1:0]  kcnt_q;
    logic [IDX_W-1:0]  idx_q;

    logic              in_ready_w;
    logic              accept_w;
    logic              start_ok_w;
    logic              last_byte_w;
    logic              word_done_w;
    logic [IDX_W-1:0]  kc_clamp_w;

    assign start_ok_w  = start && (state_q == IDLE);
    assign accept_w    = bus.in_valid && in_ready_w;
    assign word_done_w = accept_w && last_byte_w;
    assign kc_clamp_w  = (kernel_cnt > IDX_W'(NUM_KERNELS)) ? IDX_W'(NUM_KERNELS)
                                                            : kernel_cnt;

    weight_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok_w),
        .accept_i     (accept_w),
        .data_i       (bus.in_data),
        .word_o       (bus.weight_data),
        .word_valid_o (bus.readen),
        .last_byte_o  (last_byte_w)
    );

    assign bus.in_ready = in_ready_w;
    assign bus.in_index = idx_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        in_ready_w = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (kc_clamp_w == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready_w = 1'b1;
                // kc_q is at least 1 here, so kc_q-1 cannot underflow
                if (word_done_w && (kcnt_q == kc_q - IDX_W'(1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Kernel count latch, kernel counter and write index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_q   <= '0;
            kcnt_q <= '0;
            idx_q  <= '0;
        end else if (start_ok_w) begin
            kc_q   <= kc_clamp_w;
            kcnt_q <= '0;
        end else if (word_done_w) begin
            idx_q  <= kcnt_q;
            kcnt_q <= kcnt_q + IDX_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ============================================================================
// Module      : tb_weight_loader
// Description : Self-checking bench for weight_loader: table of load
//               scenarios plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_loader;
    import weight_loader_pkg::*;

    typedef struct {
        logic [2:0]  kc;
        logic [7:0]  base;
        bit          stall;
        bit          restart;
        int          exp_writes;
        logic [71:0] exp_last_word;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] kernel_cnt;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    weight_loader_if bus();

    weight_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kernel_cnt (kernel_cnt),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] model(input logic [7:0] base, input int k);
        logic [71:0] w;
        w = '0;
        for (int t = 0; t < TAPS; t++) begin
            w = {w[63:0], 8'(int'(base) + TAPS*k + t)};
        end
        return w;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},    72'(bus.in_ready),    72'h0);
        chk({tag, "_readen"},      72'(bus.readen),      72'h0);
        chk({tag, "_in_index"},    72'(bus.in_index),    72'h0);
        chk({tag, "_weight_data"}, bus.weight_data,      72'h0);
        chk({tag, "_busy"},        72'(busy),            72'h0);
        chk({tag, "_done"},        72'(done),            72'h0);
    endtask

    task automatic run_load(input vec_t v, input int vi);
        int  sent;
        int  writes;
        int  last_acc;
        int  total;
        int  cyc;
        bit  seen_done;
        bit  seen_ready;
        string tag;
        tag        = $sformatf("v%0d", vi);
        total      = v.exp_writes * TAPS;
        sent       = 0;
        writes     = 0;
        last_acc   = -1;
        seen_done  = 1'b0;
        seen_ready = 1'b0;
        @(negedge clk);
        start        = 1'b1;
        kernel_cnt   = v.kc;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!seen_done && cyc <= 600) begin
            @(negedge clk);
            start      = v.restart && (cyc == 3);
            kernel_cnt = (v.restart && (cyc == 3)) ? 3'd5 : v.kc;
            if (bus.in_ready) seen_ready = 1'b1;
            if (bus.readen) begin
                chk({tag, "_readen_after_9th"}, 72'(sent), 72'((writes + 1) * TAPS));
                chk({tag, "_word"},  bus.weight_data, model(v.base, writes));
                chk({tag, "_index"}, 72'(bus.in_index), 72'(writes));
                writes++;
            end
            if (done) begin
                seen_done = 1'b1;
                if (v.exp_writes == 0) begin
                    chk({tag, "_done_latency"}, 72'(cyc), 72'd1);
                end else begin
                    chk({tag, "_done_latency"}, 72'(cyc - last_acc), 72'd2);
                    chk({tag, "_last_word_held"}, bus.weight_data, v.exp_last_word);
                end
            end
            if (sent < total) begin
                bus.in_valid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data  = 8'(int'(v.base) + sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                last_acc = cyc;
            end
            cyc++;
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 600 cycles", tag);
        end
        chk({tag, "_writes"}, 72'(writes), 72'(v.exp_writes));
        if (v.exp_writes == 0) chk({tag, "_in_ready_never"}, 72'(seen_ready), 72'h0);
        @(negedge clk);
        chk({tag, "_busy_fell"}, 72'(busy), 72'h0);
    endtask

    vec_t vecs[7];

    initial begin
        int sent;
        int guard;
        vec_t rv;

        checks = 0;
        errors = 0;

        vecs[0] = '{kc: 3'd1, base: 8'h01, stall: 1'b0, restart: 1'b0, exp_writes: 1,
                    exp_last_word: 72'h010203040506070809};
        vecs[1] = '{kc: 3'd6, base: 8'h00, stall: 1'b0, restart: 1'b0, exp_writes: 6,
                    exp_last_word: 72'h2D2E2F303132333435};
        vecs[2] = '{kc: 3'd2, base: 8'h10, stall: 1'b1, restart: 1'b0, exp_writes: 2,
                    exp_last_word: 72'h191A1B1C1D1E1F2021};
        vecs[3] = '{kc: 3'd7, base: 8'h40, stall: 1'b0, restart: 1'b0, exp_writes: 6,
                    exp_last_word: 72'h6D6E6F707172737475};
        vecs[4] = '{kc: 3'd0, base: 8'h00, stall: 1'b0, restart: 1'b0, exp_writes: 0,
                    exp_last_word: 72'h0};
        vecs[5] = '{kc: 3'd3, base: 8'hF0, stall: 1'b1, restart: 1'b0, exp_writes: 3,
                    exp_last_word: 72'h02030405060708090A};
        vecs[6] = '{kc: 3'd2, base: 8'h80, stall: 1'b0, restart: 1'b1, exp_writes: 2,
                    exp_last_word: 72'h898A8B8C8D8E8F9091};

        rst          = 1'b1;
        start        = 1'b0;
        kernel_cnt   = 3'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i], i);
        end

        // Reset in the middle of kernel 1 of a two-kernel load
        @(negedge clk);
        start      = 1'b1;
        kernel_cnt = 3'd2;
        @(negedge clk);
        start = 1'b0;
        sent  = 0;
        guard = 0;
        while (sent < 13 && guard < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'hC0 + sent);
            if (bus.in_ready) sent++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("midload_busy_before_rst", 72'(busy), 72'h1);
        #2 rst = 1'b1;
        #1 chk_all_zero("midload_rst");
        @(negedge clk);
        rst = 1'b0;

        rv = '{kc: 3'd1, base: 8'hA0, stall: 1'b0, restart: 1'b0, exp_writes: 1,
               exp_last_word: 72'hA0A1A2A3A4A5A6A7A8};
        run_load(rv, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
